reg_rst_async_en: RTL and testbench



---
 rtl/base_pkg.sv | 4 +
 rtl/reg_bit_cell.sv | 32 +++
 rtl/reg_rst_async_en.sv | 41 ++++
 tb/tb_reg_rst_async_en.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// Shared constants for the base register primitives.
package base_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
endpackage : base_pkg

// File: rtl/reg_bit_cell.sv
// Single-bit flop with load enable. Reset clears or presets it asynchronously, as chosen by RST_BIT.
module reg_bit_cell #(
    parameter bit RST_BIT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (i_en) begin
            bit_d = i_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_q <= RST_BIT;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign o_q = bit_q;

endmodule : reg_bit_cell

// File: rtl/reg_rst_async_en.sv
// Parameterised data register with asynchronous active-low reset and a synchronous load enable.
// One reg_bit_cell per bit, so each bit clears or presets independently to match RST_VALUE.
module reg_rst_async_en
    import base_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    generate
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("reg_rst_async_en: DATA_WIDTH must be at least 1");
        end
        if ($bits(RST_VALUE) != DATA_WIDTH) begin : g_bad_rst_value
            $error("reg_rst_async_en: RST_VALUE width must equal DATA_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] data_q;

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
        reg_bit_cell #(
            .RST_BIT (RST_VALUE[b])
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (i_en),
            .i_d     (i_data[b]),
            .o_q     (data_q[b])
        );
    end

    assign o_data = data_q;

endmodule : reg_rst_async_en

// File: tb/tb_reg_rst_async_en.sv
// Directed bench for reg_rst_async_en: default 32-bit instance, a 0xDEADBEEF-reset instance and a 1-bit instance.
module tb_reg_rst_async_en;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] data;
    logic [31:0] q32;
    logic [31:0] qdead;
    logic        en1;
    logic        d1;
    logic        q1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_rst_async_en #(
        .DATA_WIDTH (32)
    ) dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_data  (data),
        .o_data  (q32)
    );

    reg_rst_async_en #(
        .DATA_WIDTH (32),
        .RST_VALUE  (32'hDEADBEEF)
    ) dut_dead (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_data  (data),
        .o_data  (qdead)
    );

    reg_rst_async_en #(
        .DATA_WIDTH (1),
        .RST_VALUE  (1'b0)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en1),
        .i_data  (d1),
        .o_data  (q1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        data  = 32'hFFFF0000;
        en1   = 1'b0;
        d1    = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            #5;
            checks++;
            if (q32 !== 32'h00000000) begin
                failures++;
                $display("FAIL reset_q32 t=%0t got=%h want=%h", $time, q32, 32'h00000000);
            end
            checks++;
            if (qdead !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL reset_dead t=%0t got=%h want=%h", $time, qdead, 32'hDEADBEEF);
            end
            checks++;
            if (q1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_w1 t=%0t got=%b want=%b", $time, q1, 1'b0);
            end
        end
    endtask

    task automatic test_hold_en_low();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        data  = 32'hFFFF00FF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (q32 !== 32'h00000000) begin
                failures++;
                $display("FAIL hold_q32 edge=%0d got=%h want=%h", i, q32, 32'h00000000);
            end
            checks++;
            if (qdead !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL hold_dead edge=%0d got=%h want=%h", i, qdead, 32'hDEADBEEF);
            end
        end
    endtask

    task automatic test_load();
        en   = 1'b1;
        data = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (q32 !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL load_q32 got=%h want=%h", q32, 32'hFFFFFFFF);
        end
        checks++;
        if (qdead !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL load_dead got=%h want=%h", qdead, 32'hFFFFFFFF);
        end
        en   = 1'b0;
        data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q32 !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL load_hold_q32 got=%h want=%h", q32, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [4];
        vec[0] = 32'h00000001;
        vec[1] = 32'h80000000;
        vec[2] = 32'h5A5A5A5A;
        vec[3] = 32'hFFFFFFFF;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = vec[i];
            @(negedge clk);
            checks++;
            if (q32 !== vec[i]) begin
                failures++;
                $display("FAIL b2b_q32 idx=%0d got=%h want=%h", i, q32, vec[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        // Pulse reset 2 ns after a falling edge, well clear of the next rising edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q32 !== 32'h00000000) begin
            failures++;
            $display("FAIL async_rst_q32 got=%h want=%h", q32, 32'h00000000);
        end
        checks++;
        if (qdead !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL async_rst_dead got=%h want=%h", qdead, 32'hDEADBEEF);
        end
        #1;
        rst_n = 1'b1;
        en    = 1'b0;
        data  = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q32 !== 32'h00000000) begin
            failures++;
            $display("FAIL async_rel_q32 got=%h want=%h", q32, 32'h00000000);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        data  = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (q32 !== 32'h00000000) begin
            failures++;
            $display("FAIL prio_q32 got=%h want=%h", q32, 32'h00000000);
        end
        checks++;
        if (qdead !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL prio_dead got=%h want=%h", qdead, 32'hDEADBEEF);
        end
        en    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (qdead !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL prio_rel_dead got=%h want=%h", qdead, 32'hDEADBEEF);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (q32 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL prio_load_q32 got=%h want=%h", q32, 32'hA5A5A5A5);
        end
        en = 1'b0;
    endtask

    task automatic test_width1();
        logic [2:0] en_v;
        logic [2:0] d_v;
        logic [2:0] q_v;
        en_v = 3'b101;
        d_v  = 3'b001;
        q_v  = 3'b011;
        for (int i = 0; i < 3; i++) begin
            en1 = en_v[i];
            d1  = d_v[i];
            @(negedge clk);
            checks++;
            if (q1 !== q_v[i]) begin
                failures++;
                $display("FAIL w1_step%0d got=%b want=%b", i, q1, q_v[i]);
            end
        end
        en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_en_low();
        test_load();
        test_back_to_back();
        test_async_reset();
        test_reset_priority();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_rst_async_en
